// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - write-side bus of the buffered UART transmitter
//
// Signals:
//   wr_en    producer -> tx   push wr_data into the FIFO this cycle
//   wr_data  producer -> tx   byte to transmit
//   full     tx -> producer   FIFO holds 2^FIFO_AW bytes
//   empty    tx -> producer   FIFO holds 0 bytes
//   level    tx -> producer   FIFO occupancy, 0..2^FIFO_AW
//   overflow tx -> producer   one-cycle pulse: a write was dropped because full
// Modports: master = byte producer, slave = uart_tx_buffered.

interface uart_tx_buffered_if #(
    parameter int FIFO_AW = 4
) ();
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   level;
    logic               overflow;

    modport master (
        output wr_en, wr_data,
        input  full, empty, level, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, level, overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter with byte FIFO
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst      synchronous reset, active high
//   wr       uart_tx_buffered_if.slave: wr_en/wr_data in, full/empty/level/overflow out
//   busy     high while a frame is on the line (START..STOP), continuous across
//            back-to-back frames
//   tx_done  one-cycle pulse on the last clock of each stop bit
//   TXD      serial line, idle high, LSB first
// Parameters:
//   BAUD_SET_COUNTER  clocks per bit, 2..65535
//   FIFO_AW           FIFO address width, depth = 2^FIFO_AW
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      data bits and the stop bit (11 bit times per frame).

module uart_tx_buffered #(
    parameter int BAUD_SET_COUNTER = 10416,
    parameter int FIFO_AW          = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_buffered_if.slave wr,
    output logic              busy,
    output logic              tx_done,
    output logic              TXD
);
    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LEVEL_MAX = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_SET_COUNTER - 1);
    // tx_done is registered, so it is set one clock before the stop bit ends
    localparam logic [15:0]      DONE_AT   = 16'(BAUD_SET_COUNTER - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_q;
    logic               overflow_q;
    logic [7:0]         head;
    logic               push;
    logic               pop;

    state_t             state;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               bit_end;
`ifdef UART_TX_PARITY_EN
    logic               parity;
`endif

    assign wr.full     = (level_q == LEVEL_MAX);
    assign wr.empty    = (level_q == '0);
    assign wr.level    = level_q;
    assign wr.overflow = overflow_q;

    assign head    = mem[rd_ptr];
    assign bit_end = (baud_cnt == BAUD_LAST);
    // full comes from the registered level, so a write while full is dropped
    // even when a pop happens on the same edge
    assign push    = wr.wr_en && !wr.full;
    assign pop     = !wr.empty && ((state == IDLE) || ((state == STOP) && bit_end));

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr.wr_en && wr.full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage has no reset; only locations between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

    // Frame sequencer; TXD/busy/tx_done are driven one edge ahead so the line
    // level always matches the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TXD      <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            tx_done  <= (state == STOP) && (baud_cnt == DONE_AT);
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    TXD      <= 1'b1;
                    busy     <= 1'b0;
                    if (pop) begin
                        shift  <= head;
`ifdef UART_TX_PARITY_EN
                        parity <= ^head;
`endif
                        state  <= START;
                        TXD    <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        TXD     <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            TXD   <= parity;
`else
                            state <= STOP;
                            TXD   <= 1'b1;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            TXD     <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        TXD   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            // next byte starts with no idle gap, busy stays high
                            shift  <= head;
`ifdef UART_TX_PARITY_EN
                            parity <= ^head;
`endif
                            state  <= START;
                            TXD    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    TXD   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered
module tb_uart_tx_buffered;
    localparam int B  = 4;
    localparam int AW = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic tx_done;
    logic TXD;

    uart_tx_buffered_if #(.FIFO_AW(AW)) bus ();

    uart_tx_buffered #(
        .BAUD_SET_COUNTER(B),
        .FIFO_AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr(bus),
        .busy(busy),
        .tx_done(tx_done),
        .TXD(TXD)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    int         cyc      = 0;
    int         busy_cnt = 0;
    int         done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic counter();
        forever begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cnt++;
            if (tx_done === 1'b1) done_q.push_back(cyc);
        end
    endtask

    // Decodes every frame on TXD and checks it against the scoreboard,
    // including per-clock TXD level, tx_done position and busy.
    task automatic monitor();
        logic [7:0] expb;
        logic [7:0] got;
        bit         have;
        bit         aborted;
        int         errs;
        int         b;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && TXD === 1'b0) begin
                have    = (sb.size() > 0);
                expb    = have ? sb.pop_front() : 8'h00;
                errs    = 0;
                aborted = 0;
                got     = 8'h00;
                for (int i = 0; i < NB * B && !aborted; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1;
                    end else begin
                        b = i / B;
                        if (TXD !== frame_bit(expb, b)) errs++;
                        if (b >= 1 && b <= 8 && (i % B) == B / 2) got[b-1] = TXD;
                        if (tx_done !== (i == NB * B - 1)) errs++;
                        if (busy !== 1'b1) errs++;
                    end
                end
                if (!aborted) begin
                    check("frame expected", 32'(have), 32'd1);
                    check("frame byte", 32'(got), 32'(expb));
                    check("frame timing errors", 32'(errs), 32'd0);
                end
            end else if (rst === 1'b0) begin
                check("idle tx_done", 32'(tx_done), 32'd0);
            end
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (bus.empty === 1'b1 && busy === 1'b0) ok = 1;
        end
        check("wait idle", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  b0;
        int  d0;
        bit  found;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        fork
            counter();
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("rst TXD", 32'(TXD), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst tx_done", 32'(tx_done), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        check("rst level", 32'(bus.level), 32'd0);
        check("rst empty", 32'(bus.empty), 32'd1);
        check("rst full", 32'(bus.full), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single byte, first-bit latency
        sb.push_back(8'hA5);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        check("t1 TXD at write edge", 32'(TXD), 32'd1);
        check("t1 level after write", 32'(bus.level), 32'd1);
        @(posedge clk); #1;
        check("t1 TXD start", 32'(TXD), 32'd0);
        check("t1 busy start", 32'(busy), 32'd1);
        check("t1 level after pop", 32'(bus.level), 32'd0);
        wait_idle(100);
        check("t1 busy end", 32'(busy), 32'd0);
        check("t1 empty end", 32'(bus.empty), 32'd1);

        // 2: back-to-back frames
        b0 = busy_cnt;
        d0 = done_q.size();
        sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'h55);
        push(8'h00); push(8'hFF); push(8'h55);
        wait_idle(300);
        check("t2 busy cycles", 32'(busy_cnt - b0), 32'd120);
        check("t2 tx_done count", 32'(done_q.size() - d0), 32'd3);
        if (done_q.size() - d0 == 3) begin
            check("t2 tx_done gap 1", 32'(done_q[d0+1] - done_q[d0]), 32'd40);
            check("t2 tx_done gap 2", 32'(done_q[d0+2] - done_q[d0+1]), 32'd40);
        end

        // 3: fill and overflow
        for (int k = 1; k <= 17; k++) begin
            sb.push_back(8'(k));
            push(8'(k));
        end
        check("t3 level full", 32'(bus.level), 32'd16);
        check("t3 full", 32'(bus.full), 32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h12;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        check("t3 overflow pulse", 32'(bus.overflow), 32'd1);
        check("t3 level held", 32'(bus.level), 32'd16);
        @(posedge clk); #1;
        check("t3 overflow clears", 32'(bus.overflow), 32'd0);
        wait_idle(17 * 40 + 100);

        // 4: push and pop on the same edge
        sb.push_back(8'hA1); sb.push_back(8'hB2);
        push(8'hA1); push(8'hB2);
        check("t4 level queued", 32'(bus.level), 32'd1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) found = 1;
        end
        check("t4 tx_done seen", 32'(found), 32'd1);
        check("t4 level before", 32'(bus.level), 32'd1);
        sb.push_back(8'hC4);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hC4;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        check("t4 level after", 32'(bus.level), 32'd1);
        check("t4 next start TXD", 32'(TXD), 32'd0);
        check("t4 busy held", 32'(busy), 32'd1);
        wait_idle(200);

        // 5: reset mid-frame during data bit 3
        sb.push_back(8'hC3);
        push(8'hC3);
        d0 = done_q.size();
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5 TXD after rst", 32'(TXD), 32'd1);
        check("t5 busy after rst", 32'(busy), 32'd0);
        check("t5 level after rst", 32'(bus.level), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("t5 no tx_done", 32'(done_q.size() - d0), 32'd0);
        sb.push_back(8'h3C);
        push(8'h3C);
        wait_idle(100);

        // 6: frame length (parity build adds one bit time)
        b0 = busy_cnt;
        sb.push_back(8'h07);
        push(8'h07);
        wait_idle(100);
        check("t6 frame 07 length", 32'(busy_cnt - b0), 32'(NB * B));
        b0 = busy_cnt;
        sb.push_back(8'h03);
        push(8'h03);
        wait_idle(100);
        check("t6 frame 03 length", 32'(busy_cnt - b0), 32'(NB * B));

        repeat (5) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter, 8N1 framing, LSB first.
- A 2^FIFO_AW-entry byte FIFO decouples producers (register dumps, I2C read-back bytes) from the serial line.
- Frames are sent back-to-back while the FIFO holds data.
- Sits alongside the existing receive/echo path and drives the board TXD pin.

Parameters:
BAUD_SET_COUNTER, 10416, clocks per bit (clock frequency / baud; 100 MHz at 9600 bps); legal range 2..65535
FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16 bytes

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  8  byte to transmit
full  output  1  FIFO holds 2^FIFO_AW bytes
empty  output  1  FIFO holds 0 bytes
level  output  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW
overflow  output  1  one-cycle pulse: wr_en while full, byte dropped
busy  output  1  high while a frame is on the line (START..STOP)
tx_done  output  1  one-cycle pulse on the last clock of each stop bit
TXD  output  1  serial line, idle high

Behaviour:
- Reset (rst=1 at an edge) sets TXD=1, busy=0, tx_done=0, overflow=0, level=0, empty=1, full=0.
- Reset also clears the FIFO pointers and forces FSM=IDLE, bit counter=0 and baud counter=0.
- Reset mid-frame aborts the frame: TXD is 1 after that edge and the byte is lost.
- FIFO write: on an edge with wr_en=1 and full=0, the byte is stored and level increments.
- FIFO full: wr_en=1 with full=1 drops the byte and pulses overflow on the next cycle. This holds even if a pop occurs in the same cycle, because full is evaluated on the registered level.
- Simultaneous push and pop: level is unchanged, and both operations take effect.
- Pointers wrap modulo 2^FIFO_AW.
- Baud counter: counts 0..BAUD_SET_COUNTER-1 and restarts on each bit boundary. Every bit occupies exactly BAUD_SET_COUNTER clocks.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1, busy=0. If empty=0, pop the FIFO head into the shift register, clear the counters, and go to START.
  - START: TXD=0 for one bit time, then go to DATA with bit index 0.
  - DATA: TXD=shift[0]. At each bit end, shift right and increment the index. After bit index 7 completes, go to STOP.
  - STOP: TXD=1 for one bit time. tx_done=1 on its final clock. At that same edge: if empty=0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: a byte written at edge N into an idle, empty block is popped at edge N+1. TXD is low from edge N+1, i.e. visible 1 clock after the write is sampled.
- Frame length: 10*BAUD_SET_COUNTER clocks. busy stays high continuously across back-to-back frames.
- TXD, busy and tx_done are registered outputs; there are no combinational paths from inputs to outputs.
- level/full/empty update on the edge following the push/pop.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. TXD = even parity (XOR of the 8 data bits) for one bit time. Frame length becomes 11*BAUD_SET_COUNTER clocks.
- Undefined: no PARITY state exists, and framing is strictly 8N1 with 10 bit times.
- Ports and all other timing are identical in both builds.

Test Plan:
1. Single byte (BAUD_SET_COUNTER=4): hold rst 2 cycles, then write 0xA5.
   -> TXD low from next edge for 4 clocks, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then high 4 clocks.
   -> tx_done pulses at clock 40 of the frame; busy=0 afterwards; empty=1.
2. Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles.
   -> 3 frames with no idle gap; busy high 120 clocks; tx_done pulses exactly 3 times, 40 clocks apart.
   -> Decoded bytes are 0x00, 0xFF, 0x55.
3. Fill/overflow: with the FSM stalled mid-frame, write 18 bytes 0x01..0x12.
   -> The first is popped, level reaches 16, full=1.
   -> The 18th write gives an overflow pulse and 0x12 is never transmitted.
   -> The line outputs 0x01..0x11 in order.
4. Push+pop same cycle: write exactly on the STOP final clock with level=1.
   -> level stays 1; the next frame starts immediately; no byte is lost or duplicated.
5. Reset mid-frame: assert rst during DATA bit 3 of 0xC3.
   -> TXD=1, busy=0, level=0 after that edge; no tx_done.
   -> A subsequent write of 0x3C transmits cleanly.
6. Parity build (UART_TX_PARITY_EN defined): send 0x07.
   -> Parity bit = 1, frame is 44 clocks at BAUD_SET_COUNTER=4.
   -> Send 0x03: parity bit = 0.
